// File: rtl/debounce_pkg.sv
// Shared types, default parameters and width helper for the multi-channel
// debounce scheduler.
package debounce_pkg;

    localparam int DEF_N        = 4;
    localparam int DEF_PRESCALE = 8;
    localparam int DEF_STABLE   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Bits needed to index 'value' distinct items (returns 0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one raw asynchronous input bit.
module sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first stage a full cycle to settle.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/debounce_scheduler.sv
// Time-multiplexed debouncer: one prescaler and one compare/count datapath
// serve N channels. Each sample tick starts a scan that visits channels
// 0..N-1 on consecutive cycles.
module debounce_scheduler
    import debounce_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int STABLE   = DEF_STABLE
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic [N-1:0] in,
    output logic [N-1:0] level,
    output logic [N-1:0] pulse,
    output logic         busy
);

    localparam int CW = clog2(STABLE + 1);
    localparam int PW = clog2(PRESCALE);
    localparam int IW = (N > 1) ? clog2(N) : 1;

    localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE - 1);
    localparam logic [IW-1:0] CH_LAST   = IW'(N - 1);

    logic [N-1:0]         s;
    logic [PW-1:0]        pcnt;
    logic                 tick;
    state_t               state, state_nxt;
    logic [IW-1:0]        ch, ch_nxt;
    logic [N-1:0][CW-1:0] cnt;

    logic                 cur_s;
    logic                 cur_level;
    logic [CW-1:0]        cur_cnt;
    logic [CW-1:0]        cnt_new;
    logic                 flip;

    for (genvar k = 0; k < N; k++) begin : g_sync
        sync2 u_sync (
            .clock (clock),
            .reset (reset),
            .d     (in[k]),
            .q     (s[k])
        );
    end

    // Ticks only fire while enabled, so a prescaler frozen at its last value
    // cannot keep retriggering scans.
    assign tick = enable && (pcnt == PCNT_LAST);

    // Sample-rate prescaler; freezes in place while disabled.
    always_ff @(posedge clock) begin
        if (reset) begin
            pcnt <= '0;
        end else if (enable) begin
            pcnt <= tick ? '0 : pcnt + PW'(1);
        end
    end

    // Scan FSM state and channel pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            ch    <= '0;
        end else begin
            state <= state_nxt;
            ch    <= ch_nxt;
        end
    end

    // A scan runs to completion regardless of enable; only new ticks stop.
    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nxt = SCAN;
                    ch_nxt    = '0;
                end
            end
            SCAN: begin
                if (ch == CH_LAST) begin
                    state_nxt = IDLE;
                    ch_nxt    = '0;
                end else begin
                    ch_nxt = ch + IW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                ch_nxt    = '0;
            end
        endcase
    end

    assign busy = (state == SCAN);

    assign cur_s     = s[ch];
    assign cur_level = level[ch];
    assign cur_cnt   = cnt[ch];

    // Shared compare/count step for whichever channel the scan points at.
    always_comb begin
        flip    = 1'b0;
        cnt_new = cur_cnt;
        if (cur_s == cur_level) begin
            cnt_new = '0;
        end else if (cur_cnt == CNT_LAST) begin
            flip    = 1'b1;
            cnt_new = '0;
        end else begin
            cnt_new = cur_cnt + CW'(1);
        end
    end

    // Per-channel write-back; pulse self-clears so each rise lasts one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            level <= '0;
            pulse <= '0;
            cnt   <= '0;
        end else begin
            pulse <= '0;
            if (busy) begin
                cnt[ch] <= cnt_new;
                if (flip) begin
                    level[ch] <= cur_s;
                    pulse[ch] <= cur_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_debounce_scheduler.sv
// Self-checking bench for debounce_scheduler: expected pulses are queued when
// stimulus is applied and matched against DUT pulses as they appear.
module tb_debounce_scheduler;

    localparam int N        = 4;
    localparam int PRESCALE = 8;
    localparam int STABLE   = 3;

    logic         clock  = 1'b0;
    logic         reset  = 1'b1;
    logic         enable = 1'b1;
    logic [N-1:0] din    = '0;
    logic [N-1:0] level;
    logic [N-1:0] pulse;
    logic         busy;

    debounce_scheduler #(
        .N        (N),
        .PRESCALE (PRESCALE),
        .STABLE   (STABLE)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .in     (din),
        .level  (level),
        .pulse  (pulse),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_chk        = 0;
    int n_fail       = 0;
    int tick_org     = 0;
    int tick_in_scan = 0;

    typedef struct {
        int ch;
        int cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Cycle in which a stable change applied to channel k during cycle c
    // becomes visible on level/pulse.
    function automatic int flip_at(input int c, input int k);
        int t;
        t = tick_org;
        while (t < c + 1 - k) t += PRESCALE;
        return t + (STABLE - 1) * PRESCALE + 2 + k;
    endfunction

    // Advance to the negedge of cycle n.
    task automatic at_cycle(input int n);
        if (cyc > n) chk("schedule", cyc, n);
        while (cyc < n) @(negedge clock);
    endtask

    // Pulse monitor: every DUT pulse must match the head of the queue.
    always @(negedge clock) begin
        if (dut.tick && busy) tick_in_scan++;
        for (int k = 0; k < N; k++) begin
            if (pulse[k]) begin
                exp_t e;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", k, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_ch", k, e.ch);
                    chk("pulse_cyc", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r, p, f, c, t, e, hi;

        // Reset check
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_level", int'(level), 0);
        chk("reset_pulse", int'(pulse), 0);
        chk("reset_busy", int'(busy), 0);
        reset = 1'b0;
        r = cyc;
        tick_org = r + PRESCALE - 1;
        for (int i = 0; i <= 12; i++) begin
            at_cycle(r + i);
            chk("busy_after_reset", int'(busy), (i >= 8 && i <= 11) ? 1 : 0);
        end

        // Clean press on channel 0
        at_cycle(r + 20);
        din[0] = 1'b1;
        p = flip_at(cyc, 0);
        exp_q.push_back('{ch: 0, cyc: p});
        at_cycle(p - 1);
        chk("press_before", int'(level), 0);
        at_cycle(p);
        chk("press_level", int'(level), 1);

        // Bounce on channel 2, then hold high
        t = p + 5;
        for (int i = 0; i < 5; i++) begin
            at_cycle(t + 12 * i);
            if (i > 0) chk("bounce_hold", int'(level), 1);
            din[2] = (i % 2 == 0);
        end
        p = flip_at(t + 48, 2);
        exp_q.push_back('{ch: 2, cyc: p});
        at_cycle(p - 1);
        chk("bounce_before", int'(level), 1);
        at_cycle(p);
        chk("bounce_level", int'(level), 5);

        // Release channel 0: falls with no pulse
        at_cycle(p + 5);
        din[0] = 1'b0;
        f = flip_at(cyc, 0);
        at_cycle(f - 1);
        chk("release_before", int'(level), 5);
        at_cycle(f);
        chk("release_level", int'(level), 4);

        // Simultaneous rise on channels 0 and 3, placed mid-period so both
        // are first sampled by the same scan
        c = f + 3;
        while (((c - tick_org) % PRESCALE) != 4) c++;
        at_cycle(c);
        din[0] = 1'b1;
        din[3] = 1'b1;
        p = flip_at(c, 0);
        exp_q.push_back('{ch: 0, cyc: p});
        exp_q.push_back('{ch: 3, cyc: flip_at(c, 3)});
        at_cycle(p);
        chk("simul_level0", int'(level), 5);
        at_cycle(flip_at(c, 3));
        chk("simul_level3", int'(level), 13);

        // Drop enable mid-scan
        t = tick_org;
        while (t < cyc + 2) t += PRESCALE;
        at_cycle(t + 2);
        chk("scan_busy_at_disable", int'(busy), 1);
        enable = 1'b0;
        at_cycle(t + 4);
        chk("scan_finishes", int'(busy), 1);
        at_cycle(t + 5);
        chk("scan_ends", int'(busy), 0);
        din[1] = 1'b1;
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            at_cycle(t + 6 + i);
            if (busy) hi++;
        end
        chk("busy_while_disabled", hi, 0);
        chk("level_retained", int'(level), 13);

        // Re-enable: prescaler resumes from 1; the third scan would flip ch1.
        // Reset lands in that scan before slot 1.
        e = cyc;
        enable = 1'b1;
        at_cycle(e + 23);
        chk("scan_before_reset", int'(busy), 1);
        reset = 1'b1;
        din = '0;
        at_cycle(e + 24);
        chk("reset_mid_level", int'(level), 0);
        chk("reset_mid_busy", int'(busy), 0);
        reset = 1'b0;
        r = cyc;
        tick_org = r + PRESCALE - 1;
        for (int i = 0; i <= 12; i++) begin
            at_cycle(r + i);
            chk("busy_after_reset2", int'(busy), (i >= 8 && i <= 11) ? 1 : 0);
        end
        at_cycle(r + 40);
        chk("level_after_reset2", int'(level), 0);

        at_cycle(cyc + 5);
        chk("pulses_pending", exp_q.size(), 0);
        chk("tick_in_scan", tick_in_scan, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_scheduler.md
# debounce_scheduler

Multi-channel debounce controller that shares one sample-rate prescaler and one compare/count datapath across N push-button inputs. The datapath is time-multiplexed: on every sample tick a scan visits each channel in turn. Each channel produces a debounced level and a one-cycle rising-edge trigger pulse. It sits between raw board inputs and the control logic, replacing per-button debounce/trigger instances.

## Interface
- N, 4, number of input channels (1..16)
- PRESCALE, 8, clock cycles per sample tick; must satisfy PRESCALE > N
- STABLE, 3, consecutive differing samples required to flip a level (1..15)
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- enable  in  1  high: prescaler runs; low: no new ticks
- in  in  N  raw asynchronous button inputs
- level  out  N  debounced level per channel
- pulse  out  N  one-cycle pulse on each debounced 0->1 transition of the channel
- busy  out  1  high while a scan is in progress

## Operation
- Each in[k] passes through a two-flop synchronizer; s[k] denotes the synchronized value.
- Prescaler pcnt counts 0..PRESCALE-1 while enable=1, then wraps. tick=1 in the cycle pcnt==PRESCALE-1. With enable=0, pcnt holds its value.
- FSM states:
  - IDLE: on tick go to SCAN, ch=0.
  - SCAN: evaluate channel ch, then increment ch. After ch==N-1, go to IDLE.
- Per-channel state: level[k] and a stability counter cnt[k] of width clog2(STABLE+1).
- Evaluation of channel k:
  - If s[k]==level[k]: cnt[k] <= 0.
  - Else if cnt[k]==STABLE-1: level[k] <= s[k], cnt[k] <= 0, and pulse[k] <= 1 if s[k]==1.
  - Else: cnt[k] <= cnt[k]+1.
- A single comparator/incrementer is shared, muxed by ch. Unvisited channels hold their state.
- pulse[k] is asserted for exactly one cycle and is 0 in all other cycles. A 1->0 flip produces no pulse.
- enable falling mid-scan: the current scan completes, then the FSM stays in IDLE. cnt and level are retained.
- Reset mid-scan: all state returns to reset values on the next edge; the scan is abandoned and no pulse is emitted.
- A tick while in SCAN is impossible because PRESCALE > N. The bench asserts this never happens.

## Timing
- Reset values: level=0, pulse=0, busy=0, cnt=0, pcnt=0, state IDLE, ch=0, synchronizer flops 0.
- The tick cycle is T. SCAN occupies cycles T+1..T+N, and channel k is evaluated in cycle T+1+k.
- level[k] and pulse[k] change at the edge ending cycle T+1+k and are visible in cycle T+2+k.
- busy=1 during cycles T+1..T+N.
- in to s latency is 2 cycles.
- Minimum debounce latency: STABLE ticks after s changes, plus k+1 cycles.
- Maximum latency from a stable input change: 2 + STABLE*PRESCALE + k+1 cycles.
- A glitch spanning fewer than STABLE consecutive samples never changes level.
- STABLE=1: level follows s at every sample.

## Structure
- Package debounce_pkg holds:
  - state enum {IDLE, SCAN};
  - default parameter constants;
  - the clog2 helper function for counter and index widths.
- Sub-module sync2: two-flop synchronizer, instantiated N times (or vectored at width N).
- The prescaler, FSM, shared datapath and per-channel registers live in debounce_scheduler.

## Test plan
All scenarios use N=4, PRESCALE=8, STABLE=3, enable=1 unless stated.
- Reset check: assert reset for 2 cycles -> level=0, pulse=0, busy=0. busy first rises in cycle 8 after reset release and is high for exactly 4 cycles.
- Clean press: in[0] 0->1 and held -> level[0]=1 after the 3rd tick that samples s[0]=1, and pulse[0]=1 for exactly one cycle at that moment. Levels and pulses of channels 1..3 unchanged.
- Bounce: in[2] toggles every 12 cycles for 60 cycles, then holds 1 -> level[2] stays 0 throughout the bouncing and rises exactly 3 ticks after the last toggle is sampled. Exactly one pulse[2].
- Release: in[0] 1->0 held -> level[0] falls after 3 ticks, no pulse.
- Simultaneous: in[0] and in[3] rise in the same cycle -> both levels flip in the same scan, with pulse[0] and pulse[3] 3 cycles apart (slots 0 and 3).
- Enable/reset mid-scan: drop enable during SCAN -> the scan finishes and no further busy assertions occur; level is retained. Assert reset during SCAN with a pending flip -> level=0, no pulse, scanning resumes 8 cycles after reset release.
